// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Arbitrates the single register-file write port between the in-order
//   pipeline WB stage (always wins) and the multi-cycle mul/div unit (MCU).
//   Keeps a scoreboard of destination registers reserved by in-flight MCU ops
//   and raises the ID hazard stall. If the MCU is blocked for MAX_WAIT
//   consecutive cycles, it raises a registered pipe_hold. This freezes
//   upstream stages so that a WB bubble can open a slot for the MCU.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   wb_we, wb_waddr, wb_wdata       pipeline WB write request
//   mc_issue, mc_issue_rd           MCU accepted an op; reserve its rd
//   mc_valid, mc_rd, mc_data        MCU result pending (held until accepted)
//   mc_ready                        MCU result accepted this cycle (comb)
//   id_rs, id_rt, id_rd, id_we      ID-stage operands / destination
//   hz_stall                        ID must stall (comb)
//   pipe_hold                       freeze upstream, inject WB bubble (reg)
//   rf_we, rf_waddr, rf_wdata       register-file write port (comb)
//   busy_vec                        scoreboard, bit r = r reserved by MCU
module regfile_wb_scheduler #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   input  logic        mc_issue,
   input  logic [4:0]  mc_issue_rd,
   input  logic        mc_valid,
   input  logic [4:0]  mc_rd,
   input  logic [31:0] mc_data,
   output logic        mc_ready,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        id_we,
   output logic        hz_stall,
   output logic        pipe_hold,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] busy_vec
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

   logic              wb_used;
   logic              grant;
   logic              blocked;
   logic [31:0]       done_mask;
   logic [31:0]       busy_eff;
   logic [31:0]       busy_q, busy_d;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pipe_hold_q, pipe_hold_d;

   // Arbitration and write-port mux
   always_comb begin
      wb_used  = wb_we && (wb_waddr != 5'd0);
      grant    = mc_valid && !wb_used;
      blocked  = mc_valid && wb_used;
      mc_ready = grant;

      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (wb_used) begin
         rf_we    = 1'b1;
         rf_waddr = wb_waddr;
         rf_wdata = wb_wdata;
      end else if (mc_valid) begin
         // A result aimed at $0 still consumes the slot but writes nothing.
         rf_we    = (mc_rd != 5'd0);
         rf_waddr = mc_rd;
         rf_wdata = mc_data;
      end
   end

   // Scoreboard next state and hazard detection
   always_comb begin
      done_mask = 32'd0;
      if (grant) done_mask[mc_rd] = 1'b1;

      busy_d = busy_q & ~done_mask;
      // Issue is applied after the clear, so a same-cycle set wins.
      if (mc_issue && (mc_issue_rd != 5'd0)) busy_d[mc_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;

      // The completing result lands at the register-file falling edge, so
      // ID can read it this cycle without stalling.
      busy_eff = busy_q & ~done_mask;
      hz_stall = busy_eff[id_rs] | busy_eff[id_rt] | (id_we & busy_eff[id_rd]);
   end

   // Starvation FSM next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (blocked) begin
               cnt_d   = CNT_W'(1);
               state_d = (MAX_WAIT == 1) ? ST_HOLD : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!blocked) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if ((32'(cnt_q) + 32'd1) == 32'(MAX_WAIT)) begin
               state_d = ST_HOLD;
               cnt_d   = cnt_q + 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (!blocked) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      pipe_hold_d = (state_d == ST_HOLD);
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q      <= 32'd0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pipe_hold_q <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pipe_hold_q <= pipe_hold_d;
      end
   end

   assign pipe_hold = pipe_hold_q;
   assign busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed testbench for regfile_wb_scheduler (MAX_WAIT = 4).
module tb_regfile_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        mc_issue;
   logic [4:0]  mc_issue_rd;
   logic        mc_valid;
   logic [4:0]  mc_rd;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_we;
   logic        hz_stall;
   logic        pipe_hold;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_vec;

   int n_chk = 0;
   int n_err = 0;

   regfile_wb_scheduler #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
      .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
      .mc_ready(mc_ready),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_we(id_we),
      .hz_stall(hz_stall), .pipe_hold(pipe_hold),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h0000_AAAA;
      mc_issue = 1'b0; mc_issue_rd = 5'd0;
      mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h0000_7777;
      id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_we = 1'b0;

      // Reset with traffic present
      tick(); tick();
      chk("rst_busy", busy_vec, 32'd0);
      chk("rst_hold", {31'd0, pipe_hold}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_waddr", {27'd0, rf_waddr}, 32'd3);
      tick();
      wb_we = 1'b0; wb_waddr = 5'd0; mc_valid = 1'b0; mc_rd = 5'd0;
      tick(); tick();
      #1;
      chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
      chk("idle_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("idle_ready", {31'd0, mc_ready}, 32'd0);
      chk("idle_hold", {31'd0, pipe_hold}, 32'd0);

      // Issue rd=5, dependent ID op, then completion
      mc_issue = 1'b1; mc_issue_rd = 5'd5;
      tick();
      mc_issue = 1'b0; mc_issue_rd = 5'd0; id_rs = 5'd5;
      #1;
      chk("issue_busy", busy_vec, 32'h0000_0020);
      chk("issue_stall", {31'd0, hz_stall}, 32'd1);
      mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'h0000_1234;
      #1;
      chk("done_ready", {31'd0, mc_ready}, 32'd1);
      chk("done_rf_we", {31'd0, rf_we}, 32'd1);
      chk("done_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("done_wdata", rf_wdata, 32'h0000_1234);
      chk("done_nostall", {31'd0, hz_stall}, 32'd0);
      tick();
      mc_valid = 1'b0; mc_rd = 5'd0; id_rs = 5'd0;
      chk("done_busy", busy_vec, 32'd0);

      // WB priority over the MCU
      wb_we = 1'b1; wb_waddr = 5'd3; mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h0000_7777;
      #1;
      chk("prio_waddr", {27'd0, rf_waddr}, 32'd3);
      chk("prio_wdata", rf_wdata, 32'h0000_AAAA);
      chk("prio_ready", {31'd0, mc_ready}, 32'd0);
      tick();
      wb_we = 1'b0;
      #1;
      chk("late_waddr", {27'd0, rf_waddr}, 32'd7);
      chk("late_ready", {31'd0, mc_ready}, 32'd1);
      tick();
      mc_valid = 1'b0;
      chk("late_hold", {31'd0, pipe_hold}, 32'd0);

      // Starvation: MCU blocked every cycle
      wb_we = 1'b1; wb_waddr = 5'd4; mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'h0000_00AB;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("starve_hold_%0d", i), {31'd0, pipe_hold}, (i == 4) ? 32'd1 : 32'd0);
      end
      // Bubble has not reached WB yet in the first HOLD cycle
      chk("hold_blocked", {31'd0, mc_ready}, 32'd0);
      tick();
      chk("hold_stays", {31'd0, pipe_hold}, 32'd1);
      wb_we = 1'b0;
      #1;
      chk("hold_grant", {31'd0, mc_ready}, 32'd1);
      chk("hold_waddr", {27'd0, rf_waddr}, 32'd10);
      tick();
      mc_valid = 1'b0;
      chk("hold_release", {31'd0, pipe_hold}, 32'd0);

      // WB to $0 does not occupy the slot
      wb_we = 1'b1; wb_waddr = 5'd0; mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h0000_0099;
      #1;
      chk("wb0_ready", {31'd0, mc_ready}, 32'd1);
      chk("wb0_waddr", {27'd0, rf_waddr}, 32'd9);
      chk("wb0_rf_we", {31'd0, rf_we}, 32'd1);
      tick();
      wb_we = 1'b0; mc_valid = 1'b0;

      // MCU write to $0 is accepted but does not write
      mc_valid = 1'b1; mc_rd = 5'd0;
      #1;
      chk("mc0_ready", {31'd0, mc_ready}, 32'd1);
      chk("mc0_rf_we", {31'd0, rf_we}, 32'd0);
      tick();
      mc_valid = 1'b0;

      // Issue to $0 leaves the scoreboard unchanged
      mc_issue = 1'b1; mc_issue_rd = 5'd2;
      tick();
      mc_issue_rd = 5'd0;
      tick();
      mc_issue = 1'b0;
      chk("issue0_busy", busy_vec, 32'h0000_0004);

      // Destination hazard and same-cycle set/clear
      mc_issue = 1'b1; mc_issue_rd = 5'd6;
      tick();
      mc_issue = 1'b0; id_we = 1'b1; id_rd = 5'd6;
      #1;
      chk("waw_stall", {31'd0, hz_stall}, 32'd1);
      id_we = 1'b0;
      #1;
      chk("waw_nowe", {31'd0, hz_stall}, 32'd0);
      mc_valid = 1'b1; mc_rd = 5'd6; mc_data = 32'h0000_0066;
      mc_issue = 1'b1; mc_issue_rd = 5'd6;
      #1;
      chk("setclr_ready", {31'd0, mc_ready}, 32'd1);
      tick();
      mc_valid = 1'b0; mc_issue = 1'b0; mc_issue_rd = 5'd0; id_rd = 5'd0;
      chk("setclr_busy", busy_vec, 32'h0000_0044);

      // Asynchronous reset mid-operation
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy_vec, 32'd0);
      chk("arst_hold", {31'd0, pipe_hold}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-port scheduler and scoreboard for the 32x32 register file. It shares the single register-file write port between the in-order pipeline WB stage and the multi-cycle unit (MCU, mul/div), giving WB priority. It also tracks destination registers reserved by in-flight MCU ops and raises the ID-stage hazard stall. A starvation counter freezes the pipeline when the MCU has been blocked for too long.

## Interface
- MAX_WAIT, 4, consecutive blocked cycles before `pipe_hold` is forced; legal range ≥1.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wb_we  in  1  pipeline WB write enable.
- wb_waddr  in  5  WB destination register.
- wb_wdata  in  32  WB write data.
- mc_issue  in  1  MCU accepted an op this cycle; reserves `mc_issue_rd`.
- mc_issue_rd  in  5  destination register of the issued MCU op.
- mc_valid  in  1  MCU result pending; `mc_rd` and `mc_data` held stable until accepted.
- mc_rd  in  5  MCU result destination.
- mc_data  in  32  MCU result data.
- mc_ready  out  1  MCU result accepted this cycle (combinational).
- id_rs, id_rt  in  5 each  ID-stage source registers.
- id_rd  in  5  ID-stage destination register.
- id_we  in  1  ID instruction writes `id_rd`.
- hz_stall  out  1  ID must stall (combinational).
- pipe_hold  out  1  freeze upstream stages and inject a WB bubble (registered).
- rf_we, rf_waddr, rf_wdata  out  1/5/32  register-file write port (combinational).
- busy_vec  out  32  scoreboard, bit r set = r reserved by MCU.

## Operation
- WB slot used: `wb_used = wb_we && wb_waddr != 0`.
- Grant: `mc_ready = mc_valid && !wb_used`. WB is never stalled by this block.
- Write-port mux:
  - if `wb_used`: rf_* = wb_*.
  - else if `mc_valid`: `rf_we = (mc_rd != 0)`, `rf_waddr = mc_rd`, `rf_wdata = mc_data`.
  - else: `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`.
- Scoreboard:
  - Set bit `mc_issue_rd` on `mc_issue` when `mc_issue_rd != 0`.
  - Clear bit `mc_rd` on `mc_valid && mc_ready`.
  - Set and clear of the same bit in the same cycle: the bit stays set.
  - Bit 0 is always 0.
- Hazard:
  - `hz_stall = B[id_rs] | B[id_rt] | (id_we & B[id_rd])`, where B = `busy_vec` with the bit for the completing `mc_rd` masked off. The write lands at the register-file negedge, so ID reads new data at no penalty.
  - `mc_issue` is asserted only when `hz_stall = 0`. Issue to an already-busy register is illegal and unchecked.
- Starvation FSM (states IDLE, WAIT, HOLD; counter `cnt` sized to hold MAX_WAIT):
  - IDLE: on `mc_valid && wb_used`, set `cnt = 1` and go to WAIT, or go directly to HOLD if MAX_WAIT = 1. Otherwise stay.
  - WAIT: if `mc_ready` or `!mc_valid`, go to IDLE with `cnt = 0`. If blocked and `cnt + 1 == MAX_WAIT`, go to HOLD. Otherwise increment `cnt`.
  - HOLD: `pipe_hold = 1`. On `mc_ready` or `!mc_valid`, go to IDLE with `cnt = 0`.
- Pipeline contract: while `pipe_hold = 1`, upstream stages freeze, and from the next cycle `wb_we = 0` until `pipe_hold` drops.

## Timing
- Reset values: `busy_vec = 0`, state IDLE, `cnt = 0`, `pipe_hold = 0`. `hz_stall`, `mc_ready` and rf_* follow inputs combinationally; with all inputs 0 every output is 0.
- Reset mid-operation clears all reservations; the MCU is reset by the same `rst`.
- Write latency: 0 cycles. The grant and rf_* are valid in the same cycle, and the register file captures on the falling edge of that cycle.
- `busy_vec` updates on the posedge after issue/accept. An issue in cycle N stalls a dependent ID op from cycle N+1.
- Worst-case MCU wait: MAX_WAIT blocked cycles + 1 HOLD cycle for the bubble to reach WB, then grant.
- `pipe_hold` rises on the posedge ending the MAX_WAIT-th blocked cycle and falls on the posedge after the grant cycle.
- An MCU write to `$0` is accepted and consumes the slot, but `rf_we = 0`.

## Test plan
- Reset with `mc_valid = 1`, `wb_we = 1` -> `busy_vec = 0`, `pipe_hold = 0`. After `rst` drops, `rf_waddr` = `wb_waddr`.
- `mc_issue` rd=5; next cycle `id_rs = 5` -> `hz_stall = 1`. Later `mc_valid` rd=5 data=0x1234 with `wb_we = 0` -> `mc_ready = 1`, `rf_we = 1`, `rf_waddr = 5`, `hz_stall = 0` that cycle, and `busy_vec[5] = 0` after the edge.
- `wb_we = 1` addr 3 and `mc_valid` rd 7 in the same cycle -> `rf_waddr = 3`, `mc_ready = 0`. Next cycle `wb_we = 0` -> `rf_waddr = 7`, `mc_ready = 1`.
- MAX_WAIT = 4, `mc_valid` held with `wb_we = 1` (addr ≠ 0) every cycle -> `pipe_hold` = 1 after the 4th blocked cycle. Bench drops `wb_we` -> grant, then `pipe_hold = 0`.
- `wb_we = 1` with `wb_waddr = 0` and `mc_valid` rd 9 -> `mc_ready = 1`, `rf_waddr = 9`. Also: `mc_issue` rd 0 -> `busy_vec` unchanged.
- Same cycle: `mc_issue` rd 6 and `mc_valid && mc_ready` rd 6 -> `busy_vec[6] = 1` after the edge. Separately: `id_we = 1`, `id_rd = 6` while bit 6 is busy -> `hz_stall = 1`.
